// File: rtl/conv1_pe_pipe_if.sv
// ============================================================================
// Module   : conv1_pe_pipe_if
// Brief    : Window/weight/bias inputs and output tile bus of the conv1 PE pipe
// Revision : 1.0
// ============================================================================
`default_nettype none

interface conv1_pe_pipe_if;
    logic         enable;
    logic         in_valid;
    logic [127:0] tmp_a0;
    logic [127:0] tmp_a1;
    logic [127:0] tmp_a2;
    logic [127:0] tmp_a3;
    logic         wr_w;
    logic [287:0] weight_in;
    logic         wr_b;
    logic [7:0]   bias_in;
    logic         out_valid;
    logic [7:0]   pipe3_c0;
    logic [7:0]   pipe3_c1;
    logic [7:0]   pipe3_c2;
    logic [7:0]   pipe3_c3;
    logic [15:0]  out_count;

    modport master (
        output enable, in_valid, tmp_a0, tmp_a1, tmp_a2, tmp_a3,
               wr_w, weight_in, wr_b, bias_in,
        input  out_valid, pipe3_c0, pipe3_c1, pipe3_c2, pipe3_c3, out_count
    );

    modport slave (
        input  enable, in_valid, tmp_a0, tmp_a1, tmp_a2, tmp_a3,
               wr_w, weight_in, wr_b, bias_in,
        output out_valid, pipe3_c0, pipe3_c1, pipe3_c2, pipe3_c3, out_count
    );
endinterface

`default_nettype wire

// File: rtl/conv1_pe_pipe.sv
// ============================================================================
// Module   : conv1_pe_pipe
// Brief    : 3-stage 3x3 conv datapath producing a 2x2 tile per 4x4 window.
//            Define CONV1_PE_RELU_EN for a [0,127] clamp instead of signed sat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv1_pe_pipe #(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 8,
    parameter int BW_PER_PARAM = 8,
    parameter int OUT_SHIFT    = 7,
    parameter int BIAS_SHIFT   = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    conv1_pe_pipe_if.slave  bus
);

    localparam int CH_BW   = ACT_PER_ADDR * BW_PER_ACT;
    localparam int WORD_BW = CH_NUM * CH_BW;
    localparam int TAPS    = CH_NUM * 9;
    localparam int W_BW    = TAPS * BW_PER_PARAM;
    localparam int PROD_BW = BW_PER_ACT + BW_PER_PARAM;
    localparam int ACC_BW  = 24;

    localparam logic signed [ACC_BW-1:0] ROUND_C = ACC_BW'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_BW-1:0] SAT_MAX = 127;
`ifdef CONV1_PE_RELU_EN
    localparam logic signed [ACC_BW-1:0] SAT_MIN = 0;
`else
    localparam logic signed [ACC_BW-1:0] SAT_MIN = -128;
`endif

    logic [W_BW-1:0]                 weight_q;
    logic signed [BW_PER_PARAM-1:0]  bias_q;

    logic                            v1_q, v2_q, v3_q;
    logic signed [PROD_BW-1:0]       prod_q   [4][TAPS];
    logic signed [BW_PER_PARAM-1:0]  bias1_q;
    logic signed [ACC_BW-1:0]        sum_q    [4];
    logic [7:0]                      pipe3_q  [4];
    logic [15:0]                     out_count_q;

    logic [WORD_BW-1:0]              w_win    [4];
    logic signed [BW_PER_ACT-1:0]    w_pix    [CH_NUM][4][4];
    logic signed [BW_PER_PARAM-1:0]  w_wt     [TAPS];
    logic signed [PROD_BW-1:0]       w_prod   [4][TAPS];
    logic signed [ACC_BW-1:0]        w_sum_d  [4];
    logic signed [ACC_BW-1:0]        w_shift  [4];
    logic [7:0]                      w_out_d  [4];

    assign w_win[0] = bus.tmp_a0;
    assign w_win[1] = bus.tmp_a1;
    assign w_win[2] = bus.tmp_a2;
    assign w_win[3] = bus.tmp_a3;

    // Undo the bank ordering: pixel(r,c) sits in block (r/2,c/2), slot (r%2,c%2).
    for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar c = 0; c < 4; c++) begin : g_col
                assign w_pix[ch][r][c] =
                    w_win[(r/2)*2 + c/2][WORD_BW-1 - ch*CH_BW - ((r%2)*2 + (c%2))*BW_PER_ACT -: BW_PER_ACT];
            end
        end
    end

    for (genvar i = 0; i < TAPS; i++) begin : g_wt
        assign w_wt[i] = weight_q[W_BW-1 - i*BW_PER_PARAM -: BW_PER_PARAM];
    end

    for (genvar t = 0; t < 4; t++) begin : g_tile
        for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_pch
            for (genvar kr = 0; kr < 3; kr++) begin : g_kr
                for (genvar kc = 0; kc < 3; kc++) begin : g_kc
                    assign w_prod[t][ch*9 + kr*3 + kc] =
                        w_pix[ch][t/2 + kr][t%2 + kc] * w_wt[ch*9 + kr*3 + kc];
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < 4; t++) begin
            w_sum_d[t] = (ACC_BW'(bias1_q) <<< BIAS_SHIFT) + ROUND_C;
            for (int i = 0; i < TAPS; i++) begin
                w_sum_d[t] = w_sum_d[t] + ACC_BW'(prod_q[t][i]);
            end
        end
    end

    always_comb begin
        for (int t = 0; t < 4; t++) begin
            w_shift[t] = sum_q[t] >>> OUT_SHIFT;
            if (w_shift[t] > SAT_MAX) begin
                w_out_d[t] = SAT_MAX[7:0];
            end else if (w_shift[t] < SAT_MIN) begin
                w_out_d[t] = SAT_MIN[7:0];
            end else begin
                w_out_d[t] = w_shift[t][7:0];
            end
        end
    end

    // Parameter registers load independently of enable; a window captures them at its S1 edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_q <= '0;
            bias_q   <= '0;
        end else begin
            if (bus.wr_w) weight_q <= bus.weight_in;
            if (bus.wr_b) bias_q   <= bus.bias_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_count_q <= '0;
        end else begin
            v1_q <= bus.in_valid & bus.enable;
            v2_q <= v1_q & bus.enable;
            v3_q <= v2_q & bus.enable;
            if (v2_q && bus.enable) out_count_q <= out_count_q + 16'd1;
        end
    end

    // Data stages advance only with a valid beat so outputs hold between tiles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias1_q <= '0;
            for (int t = 0; t < 4; t++) begin
                sum_q[t]   <= '0;
                pipe3_q[t] <= '0;
                for (int i = 0; i < TAPS; i++) prod_q[t][i] <= '0;
            end
        end else begin
            if (bus.in_valid && bus.enable) begin
                prod_q  <= w_prod;
                bias1_q <= bias_q;
            end
            if (v1_q && bus.enable) sum_q   <= w_sum_d;
            if (v2_q && bus.enable) pipe3_q <= w_out_d;
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.pipe3_c0  = pipe3_q[0];
    assign bus.pipe3_c1  = pipe3_q[1];
    assign bus.pipe3_c2  = pipe3_q[2];
    assign bus.pipe3_c3  = pipe3_q[3];
    assign bus.out_count = out_count_q;

endmodule

`default_nettype wire

// File: tb/tb_conv1_pe_pipe.sv
// ============================================================================
// Module   : tb_conv1_pe_pipe
// Brief    : Directed self-checking bench for conv1_pe_pipe
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv1_pe_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    conv1_pe_pipe_if bus ();

    conv1_pe_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tile();
        return {bus.pipe3_c0, bus.pipe3_c1, bus.pipe3_c2, bus.pipe3_c3};
    endfunction

    task automatic set_acts(input logic [7:0] v);
        bus.tmp_a0 = {16{v}};
        bus.tmp_a1 = {16{v}};
        bus.tmp_a2 = {16{v}};
        bus.tmp_a3 = {16{v}};
    endtask

    task automatic load_w(input logic [7:0] v);
        bus.weight_in = {36{v}};
        bus.wr_w = 1'b1;
        step();
        bus.wr_w = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] v);
        bus.bias_in = v;
        bus.wr_b = 1'b1;
        step();
        bus.wr_b = 1'b0;
    endtask

    // One-cycle window pulse; returns just after the edge where out_valid rises.
    task automatic fire();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;  bus.in_valid = 1'b0;
        bus.wr_w = 1'b0;    bus.wr_b = 1'b0;
        bus.weight_in = '0; bus.bias_in = '0;
        set_acts(8'd0);
        step(); step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (tile() !== 32'h0) begin errors++; $display("FAIL reset_tile got=%h exp=0", tile()); end
        checks++; if (bus.out_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.out_count); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_acts(8'd16); load_w(8'd8); load_b(8'd0);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0; step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got=%b exp=0", bus.out_valid); end
        step(); exp_cnt++;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
        checks++; if (tile() !== {4{8'd36}}) begin errors++; $display("FAIL basic_tile got=%h exp=%h", tile(), {4{8'd36}}); end
        checks++; if (bus.out_count !== 16'(exp_cnt)) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", bus.out_count, exp_cnt); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b exp=0", bus.out_valid); end
        checks++; if (tile() !== {4{8'd36}}) begin errors++; $display("FAIL basic_hold got=%h exp=%h", tile(), {4{8'd36}}); end
    endtask

    task automatic test_bias();
        load_b(8'd1);
        fire(); exp_cnt++;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bias_valid got=%b exp=1", bus.out_valid); end
        checks++; if (tile() !== {4{8'd37}}) begin errors++; $display("FAIL bias_tile got=%h exp=%h", tile(), {4{8'd37}}); end
        checks++; if (bus.out_count !== 16'(exp_cnt)) begin errors++; $display("FAIL bias_count got=%0d exp=%0d", bus.out_count, exp_cnt); end
    endtask

    task automatic test_negative();
        logic [7:0] e;
`ifdef CONV1_PE_RELU_EN
        e = 8'h00;
`else
        e = 8'hDC;
`endif
        load_b(8'd0); load_w(8'hF8);
        fire(); exp_cnt++;
        checks++; if (tile() !== {4{e}}) begin errors++; $display("FAIL neg_tile got=%h exp=%h", tile(), {4{e}}); end
    endtask

    task automatic test_saturate();
        logic [7:0] e;
`ifdef CONV1_PE_RELU_EN
        e = 8'h00;
`else
        e = 8'h80;
`endif
        set_acts(8'd127); load_w(8'd127);
        fire(); exp_cnt++;
        checks++; if (tile() !== {4{8'h7F}}) begin errors++; $display("FAIL sat_pos got=%h exp=%h", tile(), {4{8'h7F}}); end
        load_w(8'h81);
        fire(); exp_cnt++;
        checks++; if (tile() !== {4{e}}) begin errors++; $display("FAIL sat_neg got=%h exp=%h", tile(), {4{e}}); end
    endtask

    task automatic test_layout();
        logic [127:0] a [4];
        logic [287:0] w;
        for (int k = 0; k < 4; k++) a[k] = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[(r/2)*2 + c/2][127 - 8*((r%2)*2 + (c%2)) -: 8] = 8'(2*(4*r + c));
        bus.tmp_a0 = a[0]; bus.tmp_a1 = a[1]; bus.tmp_a2 = a[2]; bus.tmp_a3 = a[3];
        w = '0;
        w[287 -: 8] = 8'd64;
        bus.weight_in = w; bus.wr_w = 1'b1; step(); bus.wr_w = 1'b0;
        fire(); exp_cnt++;
        checks++; if (tile() !== 32'h00010405) begin errors++; $display("FAIL layout_tile got=%h exp=00010405", tile()); end
    endtask

    task automatic test_back_to_back();
        set_acts(8'd16); load_w(8'd8);
        bus.in_valid = 1'b1;
        step();                                   // A sampled
        bus.weight_in = {36{8'd4}}; bus.wr_w = 1'b1;
        step();                                   // B sampled, new weights load
        bus.wr_w = 1'b0;
        step();                                   // C sampled, A out
        bus.in_valid = 1'b0;
        exp_cnt++;
        checks++; if (bus.out_valid !== 1'b1 || tile() !== {4{8'd36}}) begin errors++; $display("FAIL b2b_A got=%b/%h exp=1/%h", bus.out_valid, tile(), {4{8'd36}}); end
        step(); exp_cnt++;
        checks++; if (bus.out_valid !== 1'b1 || tile() !== {4{8'd36}}) begin errors++; $display("FAIL b2b_B got=%b/%h exp=1/%h", bus.out_valid, tile(), {4{8'd36}}); end
        step(); exp_cnt++;
        checks++; if (bus.out_valid !== 1'b1 || tile() !== {4{8'd18}}) begin errors++; $display("FAIL b2b_C got=%b/%h exp=1/%h", bus.out_valid, tile(), {4{8'd18}}); end
        checks++; if (bus.out_count !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", bus.out_count, exp_cnt); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_enable_flush();
        bus.in_valid = 1'b1; step();
        bus.in_valid = 1'b0; bus.enable = 1'b0; step();
        bus.enable = 1'b1; step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid2 got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_count !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_count got=%0d exp=%0d", bus.out_count, exp_cnt); end
        checks++; if (tile() !== {4{8'd18}}) begin errors++; $display("FAIL flush_hold got=%h exp=%h", tile(), {4{8'd18}}); end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; step();
        bus.in_valid = 1'b0; step();
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
        checks++; if (tile() !== 32'h0) begin errors++; $display("FAIL rstmid_tile got=%h exp=0", tile()); end
        checks++; if (bus.out_count !== 16'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", bus.out_count); end
        step();
        rst_n = 1'b1;
        step(); step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drop got=%b exp=0", bus.out_valid); end
        // Weight and bias registers were cleared, so a fresh window yields only the rounding term.
        fire(); exp_cnt++;
        checks++; if (bus.out_valid !== 1'b1 || tile() !== 32'h0) begin errors++; $display("FAIL rstmid_params got=%b/%h exp=1/0", bus.out_valid, tile()); end
        checks++; if (bus.out_count !== 16'(exp_cnt)) begin errors++; $display("FAIL rstmid_recount got=%0d exp=%0d", bus.out_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias();
        test_negative();
        test_saturate();
        test_layout();
        test_back_to_back();
        test_enable_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
